// File: rtl/lsu_dm_ctrl.sv
// lsu_dm_ctrl -- load/store controller between the MEM stage and the data memory.
//
// Accepts one access per request handshake and checks it for type, alignment
// and range. A good access spends one cycle in ACCESS driving the DM lines.
// Every access ends with a one-cycle RESP pulse that carries the registered,
// extended load data.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   req_valid     request present
//   req_ready     high only in IDLE (accept = req_valid & req_ready)
//   req_we        1 = store, 0 = load
//   req_type      000 word, 001 half, 010 half-u, 011 byte, 100 byte-u
//   req_addr      byte address
//   req_wdata     right-aligned store data
//   resp_valid    one-cycle completion pulse
//   resp_err      access faulted (type / alignment / range)
//   resp_rdata    extended load data; 0 for stores and errors
//   stall         pipeline stall while busy or while a request waits
//   dm_addr       DM byte address
//   dm_din        DM write data
//   dm_we         DM write enable (ACCESS state, store only)
//   dm_type       normalised DM type: 000 word, 001 half, 011 byte
//   dm_dout       DM combinational read data
module lsu_dm_ctrl #(
   parameter int          ADDR_W   = 7,
   parameter int unsigned DM_BYTES = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_type,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic              stall,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_din,
   output logic              dm_we,
   output logic [2:0]        dm_type,
   input  logic [31:0]       dm_dout
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state, state_next;
   logic              cap_we;
   logic [2:0]        cap_type;
   logic              accept;
   logic              chk_err;
   logic [2:0]        norm_type;
   logic [ADDR_W+2:0] size;
   logic [ADDR_W+2:0] end_addr;
   logic [31:0]       ext;

   assign req_ready  = (state == IDLE);
   assign accept     = req_valid & req_ready;
   assign stall      = (req_valid & ~req_ready) | (state != IDLE);
   assign resp_valid = (state == RESP);
   // Combinational so that an asynchronous reset drops the write at once.
   assign dm_we      = (state == ACCESS) & cap_we;

   // Request check and type normalisation.
   always_comb begin
      size      = '0;
      chk_err   = 1'b0;
      norm_type = 3'b000;
      case (req_type)
         3'b000: begin
            size      = (ADDR_W+3)'(4);
            chk_err   = (req_addr[1:0] != 2'b00);
            norm_type = 3'b000;
         end
         3'b001, 3'b010: begin
            size      = (ADDR_W+3)'(2);
            chk_err   = req_addr[0];
            norm_type = 3'b001;
         end
         3'b011, 3'b100: begin
            size      = (ADDR_W+3)'(1);
            norm_type = 3'b011;
         end
         default: begin
            size    = (ADDR_W+3)'(1);
            chk_err = 1'b1;
         end
      endcase
      // Widened sum so an access running past the top address cannot wrap.
      end_addr = {3'b000, req_addr} + size;
      if (32'(end_addr) > DM_BYTES) chk_err = 1'b1;
   end

   // Load data extension from the captured request type.
   always_comb begin
      ext = dm_dout;
      case (cap_type)
         3'b001:  ext = {{16{dm_dout[15]}}, dm_dout[15:0]};
         3'b010:  ext = {16'h0000, dm_dout[15:0]};
         3'b011:  ext = {{24{dm_dout[7]}}, dm_dout[7:0]};
         3'b100:  ext = {24'h000000, dm_dout[7:0]};
         default: ext = dm_dout;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = chk_err ? RESP : ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_we     <= 1'b0;
         cap_type   <= '0;
         dm_addr    <= '0;
         dm_din     <= '0;
         dm_type    <= '0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         if (accept) begin
            cap_we     <= req_we;
            cap_type   <= req_type;
            dm_addr    <= req_addr;
            dm_din     <= req_wdata;
            dm_type    <= norm_type;
            resp_err   <= chk_err;
            resp_rdata <= '0;
         end
         if (state == ACCESS && !cap_we) resp_rdata <= ext;
      end
   end

endmodule
